// File: rtl/popcount_seq_pkg.sv
// rtl/popcount_seq_pkg.sv - shared FSM state and slice width for popcount_seq
package popcount_seq_pkg;

    localparam int SLICE_W = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/ones_counter7.sv
// rtl/ones_counter7.sv - 7-input ones counter built as a full-adder carry-save tree
module ones_counter7 (
    input  logic [6:0] data,
    output logic [2:0] count
);

    logic s1, c1, s2, c2, s3, c3, s4, c4;

    // Level 1: two full adders reduce six weight-1 bits.
    assign s1 = data[0] ^ data[1] ^ data[2];
    assign c1 = (data[0] & data[1]) | (data[2] & (data[0] ^ data[1]));
    assign s2 = data[3] ^ data[4] ^ data[5];
    assign c2 = (data[3] & data[4]) | (data[5] & (data[3] ^ data[4]));

    assign s3 = s1 ^ s2 ^ data[6];
    assign c3 = (s1 & s2) | (data[6] & (s1 ^ s2));

    // Three weight-2 carries collapse into bit 1 and bit 2.
    assign s4 = c1 ^ c2 ^ c3;
    assign c4 = (c1 & c2) | (c3 & (c1 ^ c2));

    assign count = {c4, s4, s3};

endmodule

// File: rtl/popcount_seq.sv
// rtl/popcount_seq.sv - sequential popcount, one 7-bit slice per cycle
module popcount_seq
    import popcount_seq_pkg::*;
#(
    parameter  int WIDTH  = 16,
    localparam int NCHUNK = (WIDTH + SLICE_W - 1) / SLICE_W,
    localparam int CW     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_parity
);

    localparam int OPW = NCHUNK * SLICE_W;
    localparam int KW  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t           state;
    state_t           next_state;
    logic [OPW-1:0]   operand;
    logic [CW-1:0]    acc;
    logic [KW-1:0]    k;
    logic [2:0]       slice_sum;
    logic             last_chunk;

    // Operand shifts right each COUNT cycle, so the live slice is always the low bits.
    ones_counter7 u_ones_counter7 (
        .data  (operand[SLICE_W-1:0]),
        .count (slice_sum)
    );

    assign last_chunk = (k == KW'(NCHUNK - 1));

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = COUNT;
            COUNT:   if (last_chunk) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            operand <= '0;
            acc     <= '0;
            k       <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        operand <= OPW'(in_data);
                        acc     <= '0;
                        k       <= '0;
                    end
                end
                COUNT: begin
                    operand <= operand >> SLICE_W;
                    acc     <= acc + CW'(slice_sum);
                    if (!last_chunk) k <= k + KW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // All handshake outputs decode registered state only.
    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign out_count  = out_valid ? acc : '0;
    assign out_parity = out_count[0];

endmodule
